set_bit_scanner: RTL

SET_BIT_SCANNER -- requirements
Module: set_bit_scanner

---
 rtl/set_bit_scanner.sv | 125 ++++++++++++
 1 files changed

// File: rtl/set_bit_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | set_bit_scanner                                                            |
// | Captures one word and emits one beat per set bit, LSB first.               |
// | Optional: SET_BIT_SCANNER_CNT_EN adds a ones_cnt popcount output.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module set_bit_scanner #(
   parameter int DATA_LEN  = 8,
   parameter int DEPTH_LEN = $clog2(DATA_LEN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_LEN-1:0]  in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DEPTH_LEN-1:0] out_pos,
   output logic                 out_last,
   output logic                 out_zero
`ifdef SET_BIT_SCANNER_CNT_EN
   ,
   output logic [DEPTH_LEN:0]   ones_cnt
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_LEN-1:0] r_shadow;
   logic [DATA_LEN-1:0] w_shadow_nxt;
   logic [DATA_LEN-1:0] w_shadow_rest;
   logic [DEPTH_LEN-1:0] w_low_pos;
   logic                w_single;

   // x & (x-1) drops the lowest set bit; zero result means at most one bit set
   assign w_shadow_rest = r_shadow & (r_shadow - DATA_LEN'(1));
   assign w_single      = (w_shadow_rest == '0);

   always_comb begin
      w_low_pos = '0;
      for (int i = DATA_LEN - 1; i >= 0; i--) begin
         if (r_shadow[i]) w_low_pos = DEPTH_LEN'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_shadow <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_pos      = '0;
      out_last     = 1'b0;
      out_zero     = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_shadow_nxt = in_data;
               w_state_nxt  = SCAN;
            end
         end
         SCAN: begin
            out_valid = 1'b1;
            out_pos   = w_low_pos;
            out_last  = w_single;
            // shadow only reaches SCAN empty when the captured word was zero
            out_zero  = (r_shadow == '0);
            if (out_ready) begin
               if (w_single) begin
                  w_state_nxt  = IDLE;
                  w_shadow_nxt = '0;
               end else begin
                  w_shadow_nxt = w_shadow_rest;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef SET_BIT_SCANNER_CNT_EN
   localparam int c_cnt_w = DEPTH_LEN + 1;

   logic [DEPTH_LEN:0] r_ones_cnt;

   function automatic logic [DEPTH_LEN:0] popcount(input logic [DATA_LEN-1:0] d);
      logic [DEPTH_LEN:0] cnt;
      cnt = '0;
      for (int i = 0; i < DATA_LEN; i++) begin
         cnt = cnt + c_cnt_w'(d[i]);
      end
      return cnt;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ones_cnt <= '0;
      end else if (r_state == IDLE && in_valid) begin
         r_ones_cnt <= popcount(in_data);
      end else if (r_state == SCAN && out_ready && w_single) begin
         r_ones_cnt <= '0;
      end
   end

   assign ones_cnt = r_ones_cnt;
`endif

endmodule
`default_nettype wire
